alg_data_distribution_mc: RTL and testbench

Parametrised multi-channel successor of the two-channel datamover read-command generator in the algorithm data path.
- Frames are written by an upstream store engine into a ring of NUM_SLOT frame buffers in DDR.
- This block issues line-by-line AXI DataMover MM2S commands to NUM_CH channels. Each channel reads one of NUM_CH consecutive frames in a sliding window.
- It sits between the frame-store control registers and NUM_CH datamover command ports.

---
 rtl/alg_dist_pkg.sv | 31 +++
 rtl/alg_edge_detect.sv | 30 +++
 rtl/alg_data_distribution_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_alg_data_distribution_mc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alg_dist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alg_dist_pkg
// Description : Shared types and helpers for the algorithm data-distribution
//               datamover command generator: FSM state enum, the command
//               width constant and a command builder for AXI DataMover MM2S.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package alg_dist_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        LINE_DONE  = 2'd2,
        FRAME_DONE = 2'd3
    } state_t;

    localparam int DM_CMD_W = 72;
    localparam int DM_BTT_W = 23;

    // MM2S command layout: {tag, addr, DRR, EOF, DSA, type(INCR), BTT}
    function automatic logic [DM_CMD_W-1:0] build_cmd(
        input logic [7:0]          tag,
        input logic [31:0]         addr,
        input logic [DM_BTT_W-1:0] btt
    );
        return {tag, addr, 1'b0, 1'b1, 6'd0, 1'b1, btt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alg_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : alg_edge_detect
// Description : Rising-edge detector for a synchronous level input. One
//               register holds the previous level; pulse is high for one
//               cycle while the new level is seen and the register is stale.
// Ports       : clk, rst_n (async active-low), level (in), pulse (out)
// Revision    : 1.0 - initial release
// ============================================================================
module alg_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
        end else begin
            r_level <= level;
        end
    end

    assign pulse = level & ~r_level;

endmodule
`default_nettype wire

// File: rtl/alg_data_distribution_mc.sv
`default_nettype none
// ============================================================================
// Module      : alg_data_distribution_mc
// Description : Issues line-by-line AXI DataMover MM2S read commands to
//               NUM_CH channels. Channel k reads frame slot (rd_slot+k) of a
//               NUM_SLOT frame ring in DDR; the window slides by one slot per
//               completed frame. Background frames re-anchor the window.
// Ports       : clk, rst_n            - clock, async active-low reset
//               base_addr, load_addr  - ring base and (edge) load/re-arm
//               frame_store, frame_type - (edge) frame written to wr_slot
//               m_axis_mm2s_cmd_*     - NUM_CH command streams
//               frame_type_o, busy, lost_read, cfg_err - status
// Options     : ALG_DIST_TAG_EN - tag = {frame_seq[3:0], channel[3:0]};
//               otherwise tag = 0.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module alg_data_distribution_mc
    import alg_dist_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned NUM_SLOT    = 4,
    parameter int unsigned CACHE_WIDTH = 29,
    parameter int unsigned LINE_BYTES  = 1024,
    parameter int unsigned NUM_LINE    = 1024,
    parameter int unsigned IMG_STRIDE  = 1049600
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  base_addr,
    input  logic                         load_addr,
    input  logic                         frame_store,
    input  logic [1:0]                   frame_type,
    output logic [DM_CMD_W*NUM_CH-1:0]   m_axis_mm2s_cmd_tdata,
    output logic [NUM_CH-1:0]            m_axis_mm2s_cmd_tvalid,
    input  logic [NUM_CH-1:0]            m_axis_mm2s_cmd_tready,
    output logic [1:0]                   frame_type_o,
    output logic                         busy,
    output logic                         lost_read,
    output logic                         cfg_err
);

    localparam int C_SLOT_W = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
    localparam int C_PEND_W = C_SLOT_W + 1;
    localparam int C_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_LINE_W = (NUM_LINE > 1) ? $clog2(NUM_LINE) : 1;
    // Low CACHE_WIDTH address bits come from the offset, the rest from base.
    localparam logic [31:0] C_LOW_MASK = 32'((64'd1 << CACHE_WIDTH) - 64'd1);

    state_t                r_state, w_state_nxt;
    logic [C_CH_W-1:0]     r_ch_idx;
    logic [C_LINE_W-1:0]   r_line_cnt;
    logic [C_SLOT_W-1:0]   r_wr_slot, w_wr_nxt;
    logic [C_SLOT_W-1:0]   r_rd_slot, w_rd_nxt;
    logic [C_SLOT_W-1:0]   r_flush_slot, w_fslot_nxt;
    logic [C_PEND_W-1:0]   r_pending, w_pend_nxt;
    logic                  r_flush_pend, w_flush_nxt;
    logic                  r_lost, w_lost_nxt;
    logic                  r_cfg_err, w_cfg_nxt;
    logic [1:0]            r_ftype, w_ftype_nxt;
    logic                  r_armed, w_armed_nxt;
    logic [31:0]           r_base, w_base_nxt;
    logic                  w_load_pulse, w_store_pulse;
    logic                  w_fs_norm, w_bg_idle, w_bg_busy;
    logic                  w_accept, w_last_ch, w_last_line;
    logic [NUM_CH-1:0]     w_vld;
`ifdef ALG_DIST_TAG_EN
    logic [3:0]            r_frame_seq;
`endif

    alg_edge_detect u_load_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (load_addr),
        .pulse (w_load_pulse)
    );

    alg_edge_detect u_store_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (frame_store),
        .pulse (w_store_pulse)
    );

    assign w_accept    = m_axis_mm2s_cmd_tready[r_ch_idx];
    assign w_last_ch   = (r_ch_idx == C_CH_W'(NUM_CH - 1));
    assign w_last_line = (r_line_cnt == C_LINE_W'(NUM_LINE - 1));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (r_pending >= C_PEND_W'(NUM_CH)) w_state_nxt = ISSUE;
            ISSUE:      if (w_accept && w_last_ch) w_state_nxt = LINE_DONE;
            LINE_DONE:  w_state_nxt = w_last_line ? FRAME_DONE : ISSUE;
            FRAME_DONE: w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Ring bookkeeping: slots, pending count, flush and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_nxt    = r_wr_slot;
        w_rd_nxt    = r_rd_slot;
        w_fslot_nxt = r_flush_slot;
        w_pend_nxt  = r_pending;
        w_flush_nxt = r_flush_pend;
        w_lost_nxt  = r_lost;
        w_cfg_nxt   = r_cfg_err;
        w_ftype_nxt = r_ftype;
        w_armed_nxt = r_armed;
        w_base_nxt  = r_base;
        w_fs_norm   = 1'b0;
        w_bg_idle   = 1'b0;
        w_bg_busy   = 1'b0;

        if (w_load_pulse && (r_state == IDLE)) begin
            w_base_nxt  = base_addr;
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
            w_pend_nxt  = '0;
            w_armed_nxt = 1'b1;
        end else begin
            if (w_load_pulse) begin
                w_cfg_nxt = 1'b1;
            end
            if (w_store_pulse && r_armed) begin
                if (r_pending == C_PEND_W'(NUM_SLOT)) begin
                    // Ring full: the new frame overwrote unread data.
                    w_lost_nxt = 1'b1;
                end else begin
                    w_wr_nxt    = r_wr_slot + C_SLOT_W'(1);
                    w_ftype_nxt = frame_type;
                    if (frame_type != 2'b00) begin
                        w_fs_norm = 1'b1;
                    end else if (r_state == IDLE) begin
                        w_bg_idle = 1'b1;
                    end else begin
                        w_bg_busy = 1'b1;
                    end
                end
            end
            if (w_bg_busy) begin
                w_flush_nxt = 1'b1;
                w_fslot_nxt = r_wr_slot;
                w_lost_nxt  = 1'b1;
            end

            if (r_state == FRAME_DONE) begin
                if (r_flush_pend) begin
                    // Deferred background flush replaces the normal slide.
                    w_rd_nxt    = r_flush_slot;
                    w_pend_nxt  = C_PEND_W'(1) + C_PEND_W'(w_fs_norm);
                    w_flush_nxt = w_bg_busy;
                end else begin
                    w_rd_nxt   = r_rd_slot + C_SLOT_W'(1);
                    w_pend_nxt = r_pending - C_PEND_W'(1) + C_PEND_W'(w_fs_norm);
                end
            end else if (w_bg_idle) begin
                w_rd_nxt   = r_wr_slot;
                w_pend_nxt = C_PEND_W'(1);
            end else if (w_fs_norm) begin
                w_pend_nxt = r_pending + C_PEND_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ch_idx     <= '0;
            r_line_cnt   <= '0;
            r_wr_slot    <= '0;
            r_rd_slot    <= '0;
            r_flush_slot <= '0;
            r_pending    <= '0;
            r_flush_pend <= 1'b0;
            r_lost       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_ftype      <= 2'b00;
            r_armed      <= 1'b0;
            r_base       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_slot    <= w_wr_nxt;
            r_rd_slot    <= w_rd_nxt;
            r_flush_slot <= w_fslot_nxt;
            r_pending    <= w_pend_nxt;
            r_flush_pend <= w_flush_nxt;
            r_lost       <= w_lost_nxt;
            r_cfg_err    <= w_cfg_nxt;
            r_ftype      <= w_ftype_nxt;
            r_armed      <= w_armed_nxt;
            r_base       <= w_base_nxt;
            case (r_state)
                ISSUE: begin
                    if (w_accept && !w_last_ch) r_ch_idx <= r_ch_idx + C_CH_W'(1);
                end
                LINE_DONE: begin
                    r_ch_idx <= '0;
                    if (!w_last_line) r_line_cnt <= r_line_cnt + C_LINE_W'(1);
                end
                FRAME_DONE: r_line_cnt <= '0;
                default: ;
            endcase
        end
    end

`ifdef ALG_DIST_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_seq <= 4'd0;
        end else if (w_load_pulse && (r_state == IDLE)) begin
            r_frame_seq <= 4'd0;
        end else if (r_state == FRAME_DONE) begin
            r_frame_seq <= r_frame_seq + 4'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-channel command generation
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [C_SLOT_W-1:0] w_slot;
        logic [31:0]         w_off;
        logic [31:0]         w_addr;
        logic [7:0]          w_tag;

        // NUM_SLOT is a power of two, so slot arithmetic wraps naturally.
        assign w_slot = r_rd_slot + C_SLOT_W'(k);
        assign w_off  = r_base + 32'(w_slot) * 32'(IMG_STRIDE)
                      + 32'(r_line_cnt) * 32'(LINE_BYTES);
        assign w_addr = (w_off & C_LOW_MASK) | (r_base & ~C_LOW_MASK);
`ifdef ALG_DIST_TAG_EN
        assign w_tag  = {r_frame_seq, 4'(k)};
`else
        assign w_tag  = 8'd0;
`endif
        assign w_vld[k] = (r_state == ISSUE) && (r_ch_idx == C_CH_W'(k));
        assign m_axis_mm2s_cmd_tdata[k*DM_CMD_W +: DM_CMD_W] =
            w_vld[k] ? build_cmd(w_tag, w_addr, DM_BTT_W'(LINE_BYTES)) : '0;
    end

    assign m_axis_mm2s_cmd_tvalid = w_vld;
    assign frame_type_o           = r_ftype;
    assign busy                   = (r_state != IDLE);
    assign lost_read              = r_lost;
    assign cfg_err                = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_alg_data_distribution_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alg_data_distribution_mc
// Description : Self-checking bench for alg_data_distribution_mc. A frame-ring
//               reference model predicts the ordered command stream and the
//               status flags; random tready stalls exercise the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alg_data_distribution_mc;

    localparam int NUM_CH      = 2;
    localparam int NUM_SLOT    = 4;
    localparam int NUM_LINE    = 4;
    localparam int LINE_BYTES  = 16;
    localparam int IMG_STRIDE  = 64;
    localparam int CACHE_WIDTH = 29;
    localparam int CW          = 72;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [31:0]            base_addr;
    logic                   load_addr;
    logic                   frame_store;
    logic [1:0]             frame_type;
    logic [CW*NUM_CH-1:0]   tdata;
    logic [NUM_CH-1:0]      tvalid;
    logic [NUM_CH-1:0]      tready;
    logic [1:0]             frame_type_o;
    logic                   busy;
    logic                   lost_read;
    logic                   cfg_err;

    alg_data_distribution_mc #(
        .NUM_CH      (NUM_CH),
        .NUM_SLOT    (NUM_SLOT),
        .CACHE_WIDTH (CACHE_WIDTH),
        .LINE_BYTES  (LINE_BYTES),
        .NUM_LINE    (NUM_LINE),
        .IMG_STRIDE  (IMG_STRIDE)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .base_addr              (base_addr),
        .load_addr              (load_addr),
        .frame_store            (frame_store),
        .frame_type             (frame_type),
        .m_axis_mm2s_cmd_tdata  (tdata),
        .m_axis_mm2s_cmd_tvalid (tvalid),
        .m_axis_mm2s_cmd_tready (tready),
        .frame_type_o           (frame_type_o),
        .busy                   (busy),
        .lost_read              (lost_read),
        .cfg_err                (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int ch; logic [CW-1:0] cmd; } exp_t;
    exp_t        exp_q[$];
    int          m_wr, m_rd, m_pend, m_fslot, m_seq, m_left;
    bit          m_armed, m_active, m_flush, m_lost, m_cfg;
    logic [1:0]  m_ft;
    logic [31:0] m_base;

    function automatic void m_reset();
        exp_q.delete();
        m_wr = 0; m_rd = 0; m_pend = 0; m_fslot = 0; m_seq = 0; m_left = 0;
        m_armed = 0; m_active = 0; m_flush = 0; m_lost = 0; m_cfg = 0;
        m_ft = 2'b00; m_base = 32'h0;
    endfunction

    function automatic logic [CW-1:0] m_cmd(int slot, int line, int k);
        logic [31:0] off, addr;
        logic [7:0]  tag;
        off  = m_base + 32'(slot * IMG_STRIDE) + 32'(line * LINE_BYTES);
        addr = {m_base[31:CACHE_WIDTH], off[CACHE_WIDTH-1:0]};
`ifdef ALG_DIST_TAG_EN
        tag  = {4'(m_seq), 4'(k)};
`else
        tag  = 8'd0;
`endif
        return {tag, addr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(LINE_BYTES)};
    endfunction

    // Start reading the next window if enough frames are buffered.
    function automatic void m_kick();
        exp_t e;
        if (!m_active && m_pend >= NUM_CH) begin
            for (int l = 0; l < NUM_LINE; l++)
                for (int k = 0; k < NUM_CH; k++) begin
                    e.ch  = k;
                    e.cmd = m_cmd((m_rd + k) % NUM_SLOT, l, k);
                    exp_q.push_back(e);
                end
            m_active = 1;
            m_left   = NUM_LINE * NUM_CH;
        end
    endfunction

    function automatic void m_frame_done();
        m_active = 0;
        m_seq    = (m_seq + 1) % 16;
        if (m_flush) begin
            m_rd = m_fslot; m_pend = 1; m_flush = 0;
        end else begin
            m_rd = (m_rd + 1) % NUM_SLOT; m_pend = m_pend - 1;
        end
        m_kick();
    endfunction

    function automatic void m_store(logic [1:0] t);
        int old;
        if (!m_armed) return;
        if (m_pend == NUM_SLOT) begin m_lost = 1; return; end
        m_ft = t;
        old  = m_wr;
        m_wr = (m_wr + 1) % NUM_SLOT;
        if (t != 2'b00)   m_pend++;
        else if (!m_active) begin m_rd = old; m_pend = 1; end
        else begin m_flush = 1; m_fslot = old; m_lost = 1; end
        m_kick();
    endfunction

    function automatic void m_load(logic [31:0] b);
        if (m_active) begin m_cfg = 1; return; end
        m_base = b; m_wr = 0; m_rd = 0; m_pend = 0; m_armed = 1; m_seq = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    int unsigned rdy_mode = 0;   // 0 always ready, 1 random, 2 never
    bit          mon_en   = 0;
    bit          hold_vld = 0;
    logic [CW*NUM_CH-1:0] hold_data;
    logic [NUM_CH-1:0]    hold_tvalid;

    task automatic do_store(input logic [1:0] t);
        @(posedge clk); #1 frame_store = 1'b1; frame_type = t;
        @(posedge clk); #1 frame_store = 1'b0;
        m_store(t);
    endtask

    task automatic do_load(input logic [31:0] b);
        @(posedge clk); #1 load_addr = 1'b1; base_addr = b;
        @(posedge clk); #1 load_addr = 1'b0;
        m_load(b);
    endtask

    task automatic wait_idle(input int budget);
        repeat (3) @(posedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !m_active) return;
        end
        check_eq("idle_timeout", {191'd0, busy}, 192'd0);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_busy"},  {191'd0, busy},      192'd0);
        check_eq({tag, "_lost"},  {191'd0, lost_read}, {191'd0, m_lost});
        check_eq({tag, "_cfg"},   {191'd0, cfg_err},   {191'd0, m_cfg});
        check_eq({tag, "_ftype"}, {190'd0, frame_type_o}, {190'd0, m_ft});
    endtask

    // ---------------- handshake monitor ----------------
    always @(negedge clk) begin
        for (int k = 0; k < NUM_CH; k++)
            tready[k] = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 99) < 55);
        if (mon_en) begin
            if (tvalid != '0)
                check_eq("onehot", {191'd0, ($countones(tvalid) == 1)}, 192'd1);
            if (hold_vld) begin
                check_eq("stable_data",  192'(tdata),  192'(hold_data));
                check_eq("stable_valid", 192'(tvalid), 192'(hold_tvalid));
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (tvalid[k] && tready[k]) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_cmd", 192'(tdata[k*CW +: CW]), 192'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_eq("cmd_ch",   192'(k), 192'(e.ch));
                        check_eq("cmd_data", 192'(tdata[k*CW +: CW]), 192'(e.cmd));
                        m_left--;
                        if (m_left == 0) m_frame_done();
                    end
                end
            end
            hold_vld    = |(tvalid & ~tready);
            hold_data   = tdata;
            hold_tvalid = tvalid;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; base_addr = 32'h0; load_addr = 1'b0;
        frame_store = 1'b0; frame_type = 2'b00; tready = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tdata",  192'(tdata),  192'd0);
        check_eq("rst_tvalid", 192'(tvalid), 192'd0);
        check_status("rst");
        rst_n = 1'b1;
        hold_vld = 0; mon_en = 1;

        // Unarmed: frame_store must be ignored
        do_store(2'b11);
        repeat (4) @(posedge clk);
        check_status("unarmed");

        // Basic window and sliding/wrapping window
        do_load(32'h2000_0000);
        do_store(2'b01); do_store(2'b01);
        wait_idle(300); check_status("t1");
        do_store(2'b10); wait_idle(300); check_status("t2a");
        do_store(2'b01); wait_idle(300); check_status("t2b");
        do_store(2'b11); wait_idle(300); check_status("t2c");

        // Random frame types with random tready stalls
        rdy_mode = 1;
        for (int it = 0; it < 10; it++) begin
            logic [1:0] t;
            t = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            do_store(t);
            if ($urandom_range(0, 1) == 1) do_store(2'b01);
            wait_idle(600); check_status("rand");
        end

        // Background frame arriving mid-frame
        for (int i = 0; i < 4 && !m_active; i++) do_store(2'b01);
        for (int i = 0; i < 400 && exp_q.size() > NUM_LINE * NUM_CH - 3; i++) @(negedge clk);
        do_store(2'b00);
        check_eq("bg_lost", {191'd0, lost_read}, 192'd1);
        wait_idle(600); check_status("bg_done");
        do_store(2'b01); wait_idle(600); check_status("bg_next");

        // Overflow with stalled outputs, then load while busy
        rdy_mode = 0;
        do_load(32'h2000_0000);
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) do_store(2'b01);
        repeat (2) @(posedge clk); #1;
        check_eq("ovf_lost", {191'd0, lost_read}, {191'd0, m_lost});
        do_load(32'h3000_0000);
        repeat (2) @(posedge clk); #1;
        check_eq("busy_cfg", {191'd0, cfg_err}, 192'd1);
        rdy_mode = 1;
        wait_idle(1500); check_status("ovf_done");

        // Asynchronous reset while a command is pending
        rdy_mode = 2;
        do_store(2'b01);
        repeat (3) @(posedge clk); #1;
        check_eq("issue_vld", 192'(tvalid), 192'd1);
        @(posedge clk); #3;
        mon_en = 0; rst_n = 1'b0;
        #1;
        check_eq("arst_tvalid", 192'(tvalid), 192'd0);
        check_eq("arst_tdata",  192'(tdata),  192'd0);
        m_reset();
        check_status("arst");
        @(posedge clk); #1 rst_n = 1'b1;
        hold_vld = 0; mon_en = 1; rdy_mode = 0;

        // Recovery after reset
        do_load(32'h2000_0100);
        do_store(2'b10); do_store(2'b01);
        wait_idle(300); check_status("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
